imem_ctrl: RTL and testbench
============================

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DEPTH        1024         instruction memory size in 32-bit words
  WAIT_CYCLES  1            extra wait states between request accept and response (0..15)
  BASE_ADDR    32'h0000_0000  byte address of word 0
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); reset reset_n, asynchronous, active-low; clock clk:
  clk          in   1   clock, rising edge
  reset_n      in   1   asynchronous active-low reset
  imem_req     in   1   fetch request from fetch stage
  imem_addr    in   32  fetch byte address
  imem_ready   out  1   controller can accept a request this cycle
  imem_valid   out  1   response valid
  imem_data    out  32  instruction word
  imem_err     out  1   access fault (misaligned or out of range)
  rsp_ready    in   1   consumer accepts response this cycle
  flush        in   1   abort in-flight access (branch/jump redirect)
  ld_we        in   1   boot-load write enable
  ld_addr      in   32  boot-load byte address
  ld_data      in   32  boot-load word

Function
REQ-003 Controller SHALL be a 3-state FSM: IDLE, WAIT, RESP.
REQ-004 imem_ready SHALL be 1 only in IDLE; imem_valid SHALL be 1 only in RESP.
REQ-005 Request accepted when imem_req=1 and imem_ready=1; imem_addr captured into an internal register that cycle.
REQ-006 On accept: WAIT_CYCLES=0 -> RESP next cycle; else -> WAIT with wait counter loaded to WAIT_CYCLES.
REQ-007 WAIT: counter decrements each cycle; leaves to RESP on the cycle counter reaches 1 (exactly WAIT_CYCLES cycles in WAIT).
REQ-008 Latency accept-edge to imem_valid=1 SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-009 Memory read SHALL be performed on the transition into RESP; imem_data/imem_err registered then and held stable throughout RESP.
REQ-010 Index = (addr - BASE_ADDR) >> 2; access in range iff addr >= BASE_ADDR and (addr - BASE_ADDR) < DEPTH*4, computed in 33-bit arithmetic (no wrap).
REQ-011 Misaligned (addr[1:0] != 0) or out-of-range access SHALL produce imem_err=1, imem_data=32'h0000_0000, same latency as a normal access.
REQ-012 RESP: rsp_ready=1 -> IDLE next cycle; rsp_ready=0 -> remain in RESP, outputs unchanged (no timeout).
REQ-013 No new request accepted in WAIT or RESP; back-to-back throughput is one fetch per WAIT_CYCLES+2 cycles.
REQ-014 flush=1 in WAIT or RESP -> IDLE next cycle, imem_valid=0, response discarded; flush in IDLE has no effect and does not block a same-cycle accept.
REQ-015 flush and rsp_ready both 1 in RESP -> IDLE (identical outcome).
REQ-016 ld_we=1 writes ld_data to word (ld_addr-BASE_ADDR)>>2 on that clock edge in any state; out-of-range or misaligned ld_addr ignored.
REQ-017 Load and read of same word on same edge -> read returns old contents; load on any earlier edge is visible to the read.
REQ-018 Memory array SHALL not be cleared by reset.

Reset
REQ-019 reset_n=0 SHALL immediately force: state IDLE, imem_ready=1 after release, imem_valid=0, imem_data=0, imem_err=0, wait counter=0, captured address=0.
REQ-020 Reset asserted mid-WAIT or mid-RESP SHALL abort the access; no response issued after release.

Verification
REQ-021 Load word 0 = 32'h0000_0093, WAIT_CYCLES=1, req addr 0x0 -> valid=1 two cycles after accept, data=32'h0000_0093, err=0.
REQ-022 Req addr 0x2 -> valid after WAIT_CYCLES+1 cycles with err=1, data=0; req addr 0x1000 (DEPTH=1024) -> err=1.
REQ-023 Hold rsp_ready=0 for 5 cycles in RESP -> valid, data, err stable all 5 cycles, ready=0; rsp_ready=1 -> ready=1 next cycle.
REQ-024 flush=1 one cycle after accept (WAIT_CYCLES=3) -> valid never asserts, ready=1 next cycle; new req then serviced normally.
REQ-025 ld_we to word 4 (0x10) with data 32'h00A0_0113 on the edge entering RESP for addr 0x10 -> old word returned; repeat with load one cycle earlier -> 32'h00A0_0113.
REQ-026 reset_n pulsed low during WAIT -> valid=0, data=0, err=0 immediately; no valid after release; memory contents preserved.

Source files
------------

// File: rtl/imem_ctrl.sv
// Instruction memory controller: single-outstanding fetch port with fixed
// wait states, alignment/range fault reporting, redirect flush, and a
// boot-load write port into an uncleared word array.
//
//   state  | meaning
//   IDLE   | ready for a fetch; the only state that accepts a request
//   WAIT   | counting down the configured wait states for the captured address
//   RESP   | response valid and held until consumed or flushed
module imem_ctrl #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic        imem_valid,
    output logic [31:0] imem_data,
    output logic        imem_err,
    input  logic        rsp_ready,
    input  logic        flush,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Byte span of the array, kept in 33 bits so the range test never wraps.
    localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  wait_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic [31:0] rd_addr;
    logic [32:0] rd_off;
    logic        rd_ok;
    logic [AW-1:0] rd_idx;
    logic [32:0] ld_off;
    logic        ld_ok;
    logic [AW-1:0] ld_idx;

    assign accept     = imem_req && (state_q == S_IDLE);
    assign enter_resp = (state_q != S_RESP) && (state_d == S_RESP);

    // With zero wait states the read happens on the accept edge, before the
    // address register has been loaded, so the live request address is used.
    assign rd_addr = (state_q == S_IDLE) ? imem_addr : addr_q;
    assign rd_off  = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    assign rd_ok   = (rd_addr[1:0] == 2'b00) && (rd_off < SPAN);
    assign rd_idx  = AW'(rd_off >> 2);

    assign ld_off  = {1'b0, ld_addr} - {1'b0, BASE_ADDR};
    assign ld_ok   = (ld_addr[1:0] == 2'b00) && (ld_off < SPAN);
    assign ld_idx  = AW'(ld_off >> 2);

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush takes priority over wait expiry and response hand-off.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; data and fault come from the response registers.
    always_comb begin
        imem_ready = (state_q == S_IDLE);
        imem_valid = (state_q == S_RESP);
        imem_data  = data_q;
        imem_err   = err_q;
    end

    // Address capture, wait countdown and the response registers loaded on entry to RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= 32'h0000_0000;
            wait_cnt_q <= 4'd0;
            data_q     <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= imem_addr;
                wait_cnt_q <= WAIT_LD;
            end else if ((state_q == S_WAIT) && (wait_cnt_q != 4'd0)) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end
            if (enter_resp) begin
                data_q <= rd_ok ? mem[rd_idx] : 32'h0000_0000;
                err_q  <= !rd_ok;
            end
        end
    end

    // Boot-load port; the array is deliberately left out of reset so code survives it.
    always_ff @(posedge clk) begin
        if (ld_we && ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: scoreboard of expected responses pushed at accept,
// popped when the response appears. A second instance with three wait
// states shares the stimulus and is used for the redirect-flush scenario.
module tb_imem_ctrl;

    localparam int unsigned W     = 1;
    localparam int unsigned W3    = 3;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req = 1'b0;
    logic [31:0] imem_addr = 32'h0;
    logic        rsp_ready = 1'b0;
    logic        flush = 1'b0;
    logic        ld_we = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic [31:0] ld_data = 32'h0;

    logic        imem_ready, imem_valid, imem_err;
    logic [31:0] imem_data;
    logic        imem_ready_3, imem_valid_3, imem_err_3;
    logic [31:0] imem_data_3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q [$];
    logic [31:0] mdl [int];

    imem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_valid(imem_valid),
        .imem_data(imem_data), .imem_err(imem_err),
        .rsp_ready(rsp_ready), .flush(flush),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(W3), .BASE_ADDR(BASE)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready_3), .imem_valid(imem_valid_3),
        .imem_data(imem_data_3), .imem_err(imem_err_3),
        .rsp_ready(rsp_ready), .flush(flush),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_map(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE};
        return (a[1:0] == 2'b00) && (off < 33'(DEPTH) * 33'd4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [32:0] model_rsp(input logic [31:0] a);
        if (!in_map(a)) return {1'b1, 32'h0000_0000};
        if (!mdl.exists(word_of(a))) return 33'bx;
        return {1'b0, mdl[word_of(a)]};
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
        if (in_map(a)) mdl[word_of(a)] = d;
    endtask

    task automatic ld_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        mdl_write(a, d);
        #1 ld_we = 1'b0;
    endtask

    // Issues one request, optionally with a load on the accept edge; ends at the
    // negedge one cycle after accept.
    task automatic do_req(input logic [31:0] a, input logic ld,
                          input logic [31:0] la, input logic [31:0] ldd);
        @(negedge clk);
        check("ready_idle", imem_ready, 1);
        imem_req = 1'b1; imem_addr = a; rsp_ready = 1'b0;
        if (ld) begin
            ld_we = 1'b1; ld_addr = la; ld_data = ldd;
        end
        @(posedge clk);
        // A load on the accept edge precedes the read unless the read is on this edge.
        if (ld && W > 0) mdl_write(la, ldd);
        exp_q.push_back(model_rsp(a));
        if (ld && W == 0) mdl_write(la, ldd);
        @(negedge clk);
        imem_req = 1'b0; ld_we = 1'b0; flush = 1'b0;
    endtask

    task automatic get_rsp(input int lat0, input int hold);
        int lat;
        logic [32:0] e;
        lat = lat0;
        while (!imem_valid && lat < int'(W) + 10) begin
            check("ready_busy", imem_ready, 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W + 1);
        if (exp_q.size() == 0) begin
            check("sb_empty_on_rsp", 1, 0);
            e = 33'bx;
        end else begin
            e = exp_q.pop_front();
        end
        check("rsp_data", imem_data, e[31:0]);
        check("rsp_err", imem_err, e[32]);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", imem_valid, 1);
            check("hold_data", imem_data, e[31:0]);
            check("hold_err", imem_err, e[32]);
            check("hold_ready", imem_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ready_after_rsp", imem_ready, 1);
        check("valid_after_rsp", imem_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic saw;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_valid", imem_valid, 0);
        check("rst_data", imem_data, 32'h0);
        check("rst_err", imem_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", imem_ready, 1);

        // Boot image, plus loads that must be ignored
        ld_word(32'h0000_0000, 32'h0000_0093);
        ld_word(32'h0000_0004, 32'h0040_0113);
        ld_word(32'h0000_0008, 32'hDEAD_BEEF);
        ld_word(32'h0000_0010, 32'h1111_1111);
        ld_word(32'h0000_0FFC, 32'hCAFE_F00D);
        ld_word(32'h0000_0013, 32'hBAD0_0001);
        ld_word(32'h0000_1000, 32'hBAD0_0002);
        ld_word(32'hFFFF_FFFC, 32'hBAD0_0003);

        // Redirect flush one cycle after accept on the three-wait-state instance
        @(negedge clk);
        check("ready3_idle", imem_ready_3, 1);
        imem_req = 1'b1; imem_addr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        imem_req = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready3", imem_ready_3, 1);
        check("flush_ready", imem_ready, 1);
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            saw = saw | imem_valid_3 | imem_valid;
        end
        check("flush_no_valid", saw, 0);
        imem_req = 1'b1; imem_addr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        imem_req = 1'b0;
        lat = 1;
        while (!imem_valid_3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency3", lat, W3 + 1);
        check("data3", imem_data_3, 32'h0000_0093);
        check("err3", imem_err_3, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ready3_after", imem_ready_3, 1);

        // Normal fetches, stall, faults and range boundaries
        do_req(32'h0000_0000, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);
        do_req(32'h0000_0008, 1'b0, 32'h0, 32'h0); get_rsp(1, 5);
        do_req(32'h0000_0002, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);
        do_req(32'h0000_1000, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);
        do_req(32'h0000_0FFC, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);
        do_req(32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);
        do_req(32'h0000_0013, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);
        do_req(32'h0000_0010, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);

        // Flush held in IDLE does not block the accept
        flush = 1'b1;
        do_req(32'h0000_0004, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);

        // Flush in RESP discards the response
        do_req(32'h0000_0008, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("resp_before_flush", imem_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_resp_valid", imem_valid, 0);
        check("flush_resp_ready", imem_ready, 1);
        void'(exp_q.pop_front());

        // Flush together with rsp_ready in RESP
        do_req(32'h0000_0000, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("resp_before_both", imem_valid, 1);
        flush = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; rsp_ready = 1'b0;
        check("both_valid", imem_valid, 0);
        check("both_ready", imem_ready, 1);
        void'(exp_q.pop_front());

        // Load on the edge entering RESP returns the old word
        do_req(32'h0000_0010, 1'b0, 32'h0, 32'h0);
        ld_we = 1'b1; ld_addr = 32'h0000_0010; ld_data = 32'h00A0_0113;
        @(posedge clk);
        mdl_write(32'h0000_0010, 32'h00A0_0113);
        #1 ld_we = 1'b0;
        @(negedge clk);
        get_rsp(2, 0);
        do_req(32'h0000_0010, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);

        // Load one edge earlier (on accept) is visible
        ld_word(32'h0000_0010, 32'h1111_1111);
        do_req(32'h0000_0010, 1'b1, 32'h0000_0010, 32'h00A0_0113); get_rsp(1, 0);

        // Reset during WAIT aborts; memory survives
        do_req(32'h0000_0008, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1;
        check("rstw_valid", imem_valid, 0);
        check("rstw_data", imem_data, 32'h0);
        check("rstw_err", imem_err, 0);
        void'(exp_q.pop_front());
        @(negedge clk);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw = saw | imem_valid;
        end
        check("rstw_no_valid", saw, 0);
        do_req(32'h0000_0008, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);
        do_req(32'h0000_0000, 1'b0, 32'h0, 32'h0); get_rsp(1, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
